// File: rtl/async_rx_sync.sv
// Clocked receiver for a 2-phase bundled-data channel.
// Synchronizes the request, buffers words in an FWFT FIFO and returns an ack.
module async_rx_sync #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inR,
    input  logic [DATA_WIDTH-1:0]   inData,
    output logic                    outA,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data,
    input  logic                    i_ready,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [SYNC_STAGES-1:0] s;
    logic                   sreq;
    logic                   phase;
    logic                   pend;
    logic                   push;
    logic                   pop;
    logic [AW-1:0]          wrPtr;
    logic [AW-1:0]          rdPtr;
    logic [AW:0]            count;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s <= '0;
        end else begin
            s <= {s[SYNC_STAGES-2:0], inR};
        end
    end

    assign sreq = s[SYNC_STAGES-1];
    assign pend = sreq ^ phase;
    // Full check uses pre-pop occupancy; a pop frees the slot for the next edge.
    assign push = pend && (count != FULL);
    assign pop  = (count != '0) && i_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= 1'b0;
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wrPtr] <= inData;
                wrPtr      <= wrPtr + 1'b1;
                phase      <= ~phase;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign outA    = phase;
    assign o_valid = (count != '0);
    assign o_data  = mem[rdPtr];
    assign o_count = count;

endmodule
